lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter WIDTH, default 16: LFSR word width in bits.
REQ-002 Parameter TAPS, default 16'b1000000001011: Galois tap mask XORed into the shifted word when feedback is 1.
REQ-003 Parameter INVERT, default 0: 1-bit value XORed into the feedback bit.
REQ-004 Parameter LOCK_COUNT, default 4: number of consecutive correct successor words needed to acquire lock.
REQ-005 Parameter LOSS_COUNT, default 8: number of consecutive wrong words that causes loss of lock.
REQ-006 Parameter CNT_WIDTH, default 32: width of the error counter.
REQ-007 clk  input  1  the single clock; all state changes on the rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 enable  input  1  qualifies in; when low, all state holds.
REQ-010 in  input  WIDTH  received LFSR word; one word per enable cycle.
REQ-011 clear_count  input  1  synchronous clear of err_count.
REQ-012 locked  output  1  registered; high while in LOCKED.
REQ-013 error  output  1  registered one-cycle pulse, one per mismatched word while LOCKED.
REQ-014 lock_lost  output  1  registered one-cycle pulse on the LOCKED->HUNT transition.
REQ-015 err_count  output  CNT_WIDTH  saturating count of error pulses.

Function
REQ-016 The step function SHALL be: fb = w[WIDTH-1] ^ INVERT; step(w) = {w[WIDTH-2:0],1'b0} ^ (fb ? TAPS : 0).
REQ-017 The FSM SHALL have two states, HUNT and LOCKED; every transition SHALL require enable=1.
REQ-018 In HUNT, each word SHALL be loaded into ref; a word is a match only if has_prev=1, in==step(ref), and in is not all-zero.
REQ-019 In HUNT, a match SHALL increment match_cnt, a non-match SHALL clear it, and has_prev SHALL be set.
REQ-020 HUNT->LOCKED SHALL occur on the word that brings match_cnt to LOCK_COUNT; locked SHALL be high on the following cycle.
REQ-021 In LOCKED, expected=step(ref), and ref SHALL load expected, not in, so that single-word errors do not propagate (flywheel).
REQ-022 In LOCKED, in!=expected SHALL pulse error, increment err_count, and increment err_run.
REQ-023 In LOCKED, in==expected SHALL clear err_run.
REQ-024 When err_run reaches LOSS_COUNT, the FSM SHALL go to HUNT, pulse lock_lost, deassert locked, and clear match_cnt, err_run and has_prev.
REQ-025 error SHALL never assert in HUNT.
REQ-026 err_count SHALL saturate at all-ones.
REQ-027 clear_count SHALL zero err_count; when it coincides with an increment, clear SHALL win.
REQ-028 clear_count SHALL act regardless of enable.

Reset
REQ-029 On reset=1 at a clock edge, the state SHALL become HUNT.
REQ-030 On reset, ref, has_prev, match_cnt, err_run, err_count, locked, error and lock_lost SHALL all become 0.
REQ-031 Reset mid-lock SHALL produce no lock_lost pulse.

Configuration
REQ-032 Macro LFSR_CHECKER_ERRCNT_EN defined: err_count and clear_count SHALL function as specified.
REQ-033 Macro LFSR_CHECKER_ERRCNT_EN undefined: err_count SHALL be constant 0, clear_count SHALL be ignored, and the counter SHALL not be synthesized; error and the FSM are unchanged.

Structure
REQ-034 Package lfsr_pkg SHALL hold the HUNT/LOCKED state encoding and the default TAPS constant.
REQ-035 Sub-module lfsr_step (combinational, parameters WIDTH, TAPS and INVERT) SHALL implement REQ-016 and SHALL be reused by the generator.

Verification
REQ-036 Reset; feed 0x0001, 0x0002, 0x0004, 0x0008, 0x0010 -> locked=1 the cycle after 0x0010; error never asserted.
REQ-037 While locked at 0x0020: feed 0x0041 (expected 0x0040), then 0x0080 -> exactly one error pulse, err_count=1, no error on 0x0080.
REQ-038 While locked at 0x4000: feed 0x8000, then 0x100B -> no error (feedback wrap with TAPS applied).
REQ-039 While locked: feed 8 consecutive 0x0000 words -> 8 error pulses; lock_lost and locked=0 after the 8th word.
REQ-040 Feed only 0x0000 words in HUNT -> locked stays 0; with CNT_WIDTH=4 and 20 errors -> err_count=15; clear_count with a coincident error -> err_count=0.
REQ-041 Reset while locked -> locked=0 the next cycle, no lock_lost pulse; macro undefined -> err_count=0 throughout.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequence checker.
// State encoding and the default Galois tap mask.
package lfsr_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lfsr_state_e;

    localparam logic [15:0] DEFAULT_TAPS = 16'b1000000001011;

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR step; shared by the checker and any generator.
// Purely combinational.
module lfsr_step #(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(16'b1000000001011),
    parameter logic             INVERT = 1'b0
) (
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] nxt
);

    logic fb;

    always_comb begin
        fb  = w[WIDTH-1] ^ INVERT;
        nxt = {w[WIDTH-2:0], 1'b0} ^ (fb ? TAPS : '0);
    end

endmodule

// File: rtl/lfsr_checker.sv
// LFSR sequence checker with hunt/lock FSM and flywheel reference.
// Define LFSR_CHECKER_ERRCNT_EN to build the saturating error counter.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
    parameter logic             INVERT     = 1'b0,
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 8,
    parameter int               CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     in,
    input  logic                 clear_count,
    output logic                 locked,
    output logic                 error,
    output logic                 lock_lost,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int RW = $clog2(LOSS_COUNT + 1);

    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             has_prev_q, has_prev_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [RW-1:0]    err_run_q, err_run_d;
    logic             locked_q, locked_d;
    logic             error_q, error_d;
    logic             lock_lost_q, lock_lost_d;
    logic [WIDTH-1:0] expected;
    logic             hunt_match;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .INVERT(INVERT)
    ) u_step (
        .w  (ref_q),
        .nxt(expected)
    );

    assign hunt_match = has_prev_q && (in == expected) && (in != '0);

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        has_prev_d  = has_prev_q;
        match_cnt_d = match_cnt_q;
        err_run_d   = err_run_q;
        locked_d    = locked_q;
        error_d     = 1'b0;
        lock_lost_d = 1'b0;
        if (enable) begin
            unique case (state_q)
                HUNT: begin
                    ref_d      = in;
                    has_prev_d = 1'b1;
                    if (hunt_match) begin
                        match_cnt_d = match_cnt_q + MW'(1);
                        if (match_cnt_d == MW'(LOCK_COUNT)) begin
                            state_d     = LOCKED;
                            locked_d    = 1'b1;
                            match_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: follow the predicted sequence, not the input.
                    ref_d = expected;
                    if (in != expected) begin
                        error_d   = 1'b1;
                        err_run_d = err_run_q + RW'(1);
                        if (err_run_d == RW'(LOSS_COUNT)) begin
                            state_d     = HUNT;
                            locked_d    = 1'b0;
                            lock_lost_d = 1'b1;
                            match_cnt_d = '0;
                            err_run_d   = '0;
                            has_prev_d  = 1'b0;
                        end
                    end else begin
                        err_run_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            ref_q       <= '0;
            has_prev_q  <= 1'b0;
            match_cnt_q <= '0;
            err_run_q   <= '0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            has_prev_q  <= has_prev_d;
            match_cnt_q <= match_cnt_d;
            err_run_q   <= err_run_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign locked    = locked_q;
    assign error     = error_q;
    assign lock_lost = lock_lost_q;

`ifdef LFSR_CHECKER_ERRCNT_EN
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    // Clear wins over a coincident increment and ignores enable.
    always_comb begin
        err_count_d = err_count_q;
        if (clear_count) begin
            err_count_d = '0;
        end else if (error_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_clear_count;
    assign unused_clear_count = clear_count;
    assign err_count          = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed and random checks of lfsr_checker against a behavioural model.
// Expects err_count activity only when LFSR_CHECKER_ERRCNT_EN is defined.
module tb_lfsr_checker;

    localparam int          LOCK_N = 4;
    localparam int          LOSS_N = 8;
    localparam logic [15:0] TAPS_V = 16'h100B;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] in = '0;
    logic        clear_count = 1'b0;
    logic        locked;
    logic        error;
    logic        lock_lost;
    logic [3:0]  err_count;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;

    // Behavioural model state
    bit          m_hunt = 1'b1;
    bit   [15:0] m_ref = '0;
    bit          m_has_prev = 1'b0;
    int          m_match = 0;
    int          m_run = 0;
    bit          m_locked = 1'b0;
    bit          m_error = 1'b0;
    bit          m_lost = 1'b0;
    int          m_cnt = 0;

    lfsr_checker #(
        .WIDTH     (16),
        .TAPS      (TAPS_V),
        .INVERT    (1'b0),
        .LOCK_COUNT(LOCK_N),
        .LOSS_COUNT(LOSS_N),
        .CNT_WIDTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in         (in),
        .clear_count(clear_count),
        .locked     (locked),
        .error      (error),
        .lock_lost  (lock_lost),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    function automatic bit [15:0] nxt(input bit [15:0] w);
        bit [16:0] dbl;
        dbl = {1'b0, w} * 2;
        return (w >= 16'h8000) ? (dbl[15:0] ^ TAPS_V) : dbl[15:0];
    endfunction

    task automatic model(input bit [15:0] w, input bit en, input bit clr,
                         input bit rst);
        bit [15:0] exp_w;
        if (rst) begin
            m_hunt = 1; m_ref = 0; m_has_prev = 0; m_match = 0; m_run = 0;
            m_locked = 0; m_error = 0; m_lost = 0; m_cnt = 0;
            return;
        end
        m_error = 0;
        m_lost  = 0;
        if (en && m_hunt) begin
            if (m_has_prev && w == nxt(m_ref) && w != 0) m_match++;
            else m_match = 0;
            m_ref = w;
            m_has_prev = 1;
            if (m_match == LOCK_N) begin
                m_hunt = 0; m_locked = 1; m_match = 0;
            end
        end else if (en) begin
            exp_w = nxt(m_ref);
            m_ref = exp_w;
            if (w != exp_w) begin
                m_error = 1;
                m_run++;
                if (m_run == LOSS_N) begin
                    m_hunt = 1; m_locked = 0; m_lost = 1;
                    m_run = 0; m_match = 0; m_has_prev = 0;
                end
            end else begin
                m_run = 0;
            end
        end
`ifdef LFSR_CHECKER_ERRCNT_EN
        if (clr) m_cnt = 0;
        else if (m_error && m_cnt < 15) m_cnt++;
`endif
    endtask

    task automatic cyc(input logic [15:0] w, input bit en = 1,
                       input bit clr = 0, input bit rst = 0);
        in = w; enable = en; clear_count = clr; reset = rst;
        @(posedge clk);
        model(w, en, clr, rst);
        #1;
        if (error) err_pulses++;
        checks++;
        assert (locked === m_locked) else begin
            errors++;
            $error("FAIL locked: observed %0b expected %0b", locked, m_locked);
        end
        checks++;
        assert (error === m_error) else begin
            errors++;
            $error("FAIL error: observed %0b expected %0b", error, m_error);
        end
        checks++;
        assert (lock_lost === m_lost) else begin
            errors++;
            $error("FAIL lock_lost: observed %0b expected %0b", lock_lost, m_lost);
        end
        checks++;
        assert (err_count === 4'(m_cnt)) else begin
            errors++;
            $error("FAIL err_count: observed %0d expected %0d", err_count, m_cnt);
        end
        @(negedge clk);
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic acquire(input bit [15:0] seed);
        bit [15:0] w;
        w = seed;
        for (int i = 0; i <= LOCK_N; i++) begin
            cyc(w);
            w = nxt(w);
        end
    endtask

    initial begin
        bit [15:0] w;
        int ecnt_exp;
        @(negedge clk);
        cyc(16'h1234, 1, 1, 1);
        cyc(16'h0000, 0, 0, 1);
        expect_int("reset_locked", locked, 0);

        // Simple walking-one lock
        cyc(16'h0001); cyc(16'h0002); cyc(16'h0004); cyc(16'h0008);
        expect_int("pre_lock", locked, 0);
        cyc(16'h0010);
        expect_int("lock_after_0010", locked, 1);
        expect_int("no_error_hunt", err_pulses, 0);

        // Single-word error absorbed by flywheel
        cyc(16'h0020);
        cyc(16'h0041);
        expect_int("err_0041", error, 1);
        cyc(16'h0080);
        expect_int("no_err_0080", error, 0);
        expect_int("one_pulse", err_pulses, 1);
`ifdef LFSR_CHECKER_ERRCNT_EN
        ecnt_exp = 1;
`else
        ecnt_exp = 0;
`endif
        expect_int("cnt_after_one", err_count, ecnt_exp);

        // Walk up to the feedback wrap
        w = 16'h0100;
        while (w != 16'h8000) begin
            cyc(w);
            w = nxt(w);
        end
        cyc(16'h8000);
        cyc(16'h100B);
        expect_int("wrap_no_err", error, 0);
        expect_int("still_locked", locked, 1);

        // Eight zero words drop lock
        err_pulses = 0;
        for (int i = 0; i < LOSS_N; i++) cyc(16'h0000);
        expect_int("zero_pulses", err_pulses, LOSS_N);
        expect_int("lost_pulse", lock_lost, 1);
        expect_int("lost_unlocked", locked, 0);

        // Zeros never lock, never flag
        err_pulses = 0;
        for (int i = 0; i < 10; i++) cyc(16'h0000);
        expect_int("zero_hunt_lock", locked, 0);
        expect_int("zero_hunt_err", err_pulses, 0);

        // Saturation: 20 isolated errors
        cyc(16'h0000, 1, 1);
        acquire(16'hACE1);
        for (int i = 0; i < 20; i++) begin
            cyc(~nxt(m_ref));
            cyc(nxt(m_ref));
        end
`ifdef LFSR_CHECKER_ERRCNT_EN
        ecnt_exp = 15;
`else
        ecnt_exp = 0;
`endif
        expect_int("saturated", err_count, ecnt_exp);

        // Clear wins over coincident error, and ignores enable
        cyc(~nxt(m_ref), 1, 1);
        expect_int("clear_coincident", err_count, 0);
        cyc(~nxt(m_ref));
        cyc(16'h5555, 0, 1);
        expect_int("clear_disabled", err_count, 0);

        // Hold when disabled
        cyc(16'hFFFF, 0);
        cyc(16'h0000, 0);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70) w = nxt(m_ref);
            else if (r < 80) w = 16'h0000;
            else w = 16'($urandom);
            cyc(w, $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 149) == 0);
        end

        // Reset while locked: no lock_lost
        acquire(16'h0BAD);
        expect_int("relock", locked, 1);
        cyc(16'h0000, 1, 0, 1);
        expect_int("reset_unlock", locked, 0);
        expect_int("reset_no_lost", lock_lost, 0);
        cyc(nxt(16'h0000) ^ 16'h1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
